// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_pkg: shared types and constants for the multiplexed seven-segment
// scan decoder. Build option: SEGDEC_TIMEOUT_EN (see seg_scan_decoder.sv).
package seg_scan_pkg;

   // Scan FSM: wait for a single selected digit, let it settle, hold it
   typedef enum logic [1:0] {
      WAIT_SEL = 2'd0,
      SETTLE   = 2'd1,
      LATCHED  = 2'd2
   } scanState_t;

   // Segment patterns ordered {g,f,e,d,c,b,a}, active-high; 6 and 9 carry tails
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Nibble reported for a blank or undecodable digit
   localparam logic [3:0] BCD_INVALID = 4'hF;

   // Number of asserted (low) digit-select lines
   function automatic logic [3:0] countLow(input logic [7:0] cat);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, ~cat[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: display-side bus (digit select and segments) plus the
// decoded frame outputs. The display/driver side is the master, the decoder
// is the slave.
interface seg_scan_decoder_if;

   logic [7:0]  cat;
   logic [6:0]  seg;
   logic [31:0] digits;
   logic [7:0]  blank;
   logic        frame_valid;
   logic        digit_err;
   logic        stale;

   modport master (
      output cat, seg,
      input  digits, blank, frame_valid, digit_err, stale
   );

   modport slave (
      input  cat, seg,
      output digits, blank, frame_valid, digit_err, stale
   );

endinterface

// File: rtl/seg_scan_decoder_seg7.sv
// seg7_to_bcd: combinational seven-segment to BCD decoder. Blank patterns
// report BCD_INVALID with isBlank_o; unknown patterns report BCD_INVALID
// with isIllegal_o.
module seg7_to_bcd
   import seg_scan_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       isBlank_o,
   output logic       isIllegal_o
);

   // Pattern lookup; anything not in the table is flagged illegal
   always_comb begin
      bcd_o       = BCD_INVALID;
      isBlank_o   = 1'b0;
      isIllegal_o = 1'b0;
      case (seg_i)
         SEG_0:     bcd_o = 4'd0;
         SEG_1:     bcd_o = 4'd1;
         SEG_2:     bcd_o = 4'd2;
         SEG_3:     bcd_o = 4'd3;
         SEG_4:     bcd_o = 4'd4;
         SEG_5:     bcd_o = 4'd5;
         SEG_6:     bcd_o = 4'd6;
         SEG_7:     bcd_o = 4'd7;
         SEG_8:     bcd_o = 4'd8;
         SEG_9:     bcd_o = 4'd9;
         SEG_BLANK: isBlank_o = 1'b1;
         default:   isIllegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 8-digit seven-segment display
// (active-low one-hot digit select), waits for each digit to be stable,
// decodes it into a shadow frame and publishes the frame once all eight
// digits have been seen.
// Build option: SEGDEC_TIMEOUT_EN enables the stale-display timeout;
// without it no timeout counter exists and stale is tied low.
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int STABLE_CYC     = 4,
   parameter int TIMEOUT_CYC    = 100000,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_decoder_if.slave bus
);

   localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
   localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYC - 1);

   scanState_t  state_q;
   logic [CNT_W-1:0] stableCnt_q;
   logic [7:0]  catHold_q;
   logic [6:0]  segHold_q;
   logic [31:0] shadowDigits_q, shadowDigits_d;
   logic [7:0]  shadowBlank_q, shadowBlank_d;
   logic [7:0]  seen_q, seen_d;
   logic [31:0] digits_q;
   logic [7:0]  blank_q;
   logic        frameValid_q;
   logic        digitErr_q;

   logic [6:0]  segEff;
   logic [3:0]  lowCount;
   logic        inputsSame;
   logic        accept;
   logic [7:0]  acceptMask;
   logic        frameDone;
   logic [3:0]  decBcd;
   logic        decBlank;
   logic        decIllegal;

   assign segEff     = (SEG_ACTIVE_LOW != 0) ? ~bus.seg : bus.seg;
   assign lowCount   = countLow(bus.cat);
   assign inputsSame = (bus.cat == catHold_q) && (segEff == segHold_q);
   assign accept     = (state_q == SETTLE) && inputsSame &&
                       (lowCount == 4'd1) && (stableCnt_q == STABLE_MAX);
   assign acceptMask = accept ? ~catHold_q : 8'h00;
   assign frameDone  = (seen_q == 8'hFF);

   seg7_to_bcd u_seg7 (
      .seg_i       (segHold_q),
      .bcd_o       (decBcd),
      .isBlank_o   (decBlank),
      .isIllegal_o (decIllegal)
   );

   // Shadow frame update: the accepted digit lands in its slot, and seen bits
   // restart after a completed frame while still recording a same-cycle accept
   always_comb begin
      shadowDigits_d = shadowDigits_q;
      shadowBlank_d  = shadowBlank_q;
      seen_d         = (frameDone ? 8'h00 : seen_q) | acceptMask;
      for (int i = 0; i < 8; i++) begin
         if (acceptMask[i]) begin
            shadowDigits_d[4*i +: 4] = decBcd;
            shadowBlank_d[i]         = decBlank;
         end
      end
   end

   // Scan FSM, shadow/frame registers and sticky error flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= WAIT_SEL;
         stableCnt_q    <= '0;
         catHold_q      <= 8'hFF;
         segHold_q      <= 7'h00;
         shadowDigits_q <= 32'hFFFF_FFFF;
         shadowBlank_q  <= 8'hFF;
         seen_q         <= 8'h00;
         digits_q       <= 32'hFFFF_FFFF;
         blank_q        <= 8'hFF;
         frameValid_q   <= 1'b0;
         digitErr_q     <= 1'b0;
      end else begin
         shadowDigits_q <= shadowDigits_d;
         shadowBlank_q  <= shadowBlank_d;
         seen_q         <= seen_d;
         frameValid_q   <= frameDone;
         if (frameDone) begin
            digits_q <= shadowDigits_q;
            blank_q  <= shadowBlank_q;
         end
         if (accept && decIllegal) begin
            digitErr_q <= 1'b1;
         end
         case (state_q)
            WAIT_SEL: begin
               if (lowCount == 4'd1) begin
                  state_q     <= SETTLE;
                  stableCnt_q <= '0;
                  catHold_q   <= bus.cat;
                  segHold_q   <= segEff;
               end else if (lowCount > 4'd1) begin
                  digitErr_q <= 1'b1;
               end
            end
            SETTLE: begin
               if (lowCount > 4'd1) begin
                  digitErr_q <= 1'b1;
                  state_q    <= WAIT_SEL;
               end else if (lowCount == 4'd0) begin
                  state_q <= WAIT_SEL;
               end else if (!inputsSame) begin
                  stableCnt_q <= '0;
                  catHold_q   <= bus.cat;
                  segHold_q   <= segEff;
               end else if (accept) begin
                  state_q <= LATCHED;
               end else if (stableCnt_q != STABLE_MAX) begin
                  stableCnt_q <= stableCnt_q + 1'b1;
               end
            end
            LATCHED: begin
               if (bus.cat != catHold_q) begin
                  state_q <= WAIT_SEL;
               end else if (segEff != segHold_q) begin
                  state_q     <= SETTLE;
                  stableCnt_q <= '0;
                  segHold_q   <= segEff;
               end
            end
            default: state_q <= WAIT_SEL;
         endcase
      end
   end

   assign bus.digits      = digits_q;
   assign bus.blank       = blank_q;
   assign bus.frame_valid = frameValid_q;
   assign bus.digit_err   = digitErr_q;

`ifdef SEGDEC_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

   logic [TO_W-1:0] timeoutCnt_q;
   logic            stale_q;

   // Idle-cycle counter: saturates at the limit and restarts on every accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timeoutCnt_q <= '0;
         stale_q      <= 1'b0;
      end else if (accept) begin
         timeoutCnt_q <= '0;
         stale_q      <= 1'b0;
      end else if (timeoutCnt_q != TO_MAX) begin
         timeoutCnt_q <= timeoutCnt_q + 1'b1;
         if (timeoutCnt_q == TO_MAX - 1'b1) begin
            stale_q <= 1'b1;
         end
      end
   end

   assign bus.stale = stale_q;
`else
   assign bus.stale = 1'b0;
`endif

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4: cycles cat/seg must hold unchanged before a digit is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000: cycles without an accepted digit before stale is raised.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 0: 1 inverts seg before decoding.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 cat  input  8  digit select, active-low one-hot; bit i low selects digit i.
REQ-007 seg  input  7  segments {g,f,e,d,c,b,a}, active-high unless SEG_ACTIVE_LOW=1.
REQ-008 digits  output  32  BCD nibble per digit; digit i at [4i+3:4i].
REQ-009 blank  output  8  bit i set when digit i was blank (all segments off).
REQ-010 frame_valid  output  1  one-cycle pulse when digits/blank update.
REQ-011 digit_err  output  1  sticky; set on an illegal pattern or illegal select.
REQ-012 stale  output  1  set when no digit accepted for TIMEOUT_CYC cycles.

Function
REQ-013 SHALL run FSM states WAIT_SEL, SETTLE, LATCHED.
REQ-014 WAIT_SEL: exactly one cat bit low -> SETTLE, stability counter cleared; all cat bits high -> remain.
REQ-015 SETTLE: any cat/seg change -> counter restarts; counter reaching STABLE_CYC-1 with inputs unchanged -> accept digit, go LATCHED.
REQ-016 LATCHED: any change of cat -> WAIT_SEL; seg change with cat unchanged -> SETTLE, counter cleared.
REQ-017 Accept: decoded value written to shadow nibble i, shadow blank bit i, and seen bit i set, same cycle.
REQ-018 Decoding: standard 0-9 patterns (6 and 9 with tails) -> BCD; 0x00 -> nibble 0xF and blank bit 1; any other pattern -> nibble 0xF, blank 0, digit_err set.
REQ-019 More than one cat bit low: SHALL not accept, set digit_err, go WAIT_SEL.
REQ-020 When all 8 seen bits are set: next cycle copy shadow to digits/blank, pulse frame_valid, clear seen bits; frame latency = 1 cycle after the 8th accept.
REQ-021 Accept on the same cycle seen clears: the new digit SHALL count toward the next frame.
REQ-022 Re-accepting an already-seen digit before the frame completes SHALL overwrite its shadow nibble and SHALL NOT pulse frame_valid.
REQ-023 Stability and timeout counters SHALL saturate, never wrap.
REQ-024 digit_err SHALL clear only on reset.

Reset
REQ-025 On rst_n low at a clock edge: state WAIT_SEL, digits 32'hFFFF_FFFF, blank 8'hFF, frame_valid 0, digit_err 0, stale 0, seen 0, all counters 0.
REQ-026 Reset mid-SETTLE or mid-frame SHALL discard all partial shadow data.

Configuration
REQ-027 Macro SEGDEC_TIMEOUT_EN defined: timeout counter counts up each cycle without an accept, stale sets at TIMEOUT_CYC and clears on the next accept.
REQ-028 Macro SEGDEC_TIMEOUT_EN undefined: no timeout counter synthesised, stale tied 0.

Structure
REQ-029 Package seg_scan_pkg SHALL hold the FSM state enum, the 7-bit segment pattern constants for 0-9 and blank, and the BCD_INVALID (4'hF) constant.
REQ-030 Sub-module seg7_to_bcd (combinational: seg in -> bcd, is_blank, is_illegal) SHALL implement REQ-018.

Verification
REQ-031 Scan digits 0..7 showing 1,2,3,4,5,6,7,8, each held 8 cycles -> one frame_valid, digits=32'h8765_4321, blank=0, digit_err=0.
REQ-032 Digit 3 seg toggles every 2 cycles for 10 cycles, then holds 3'd pattern 8 cycles (STABLE_CYC=4) -> only the settled value accepted; digits[15:12]=4'h3.
REQ-033 cat=8'b1111_0011 for 10 cycles -> digit_err=1, no accept, no frame_valid.
REQ-034 Digit 5 seg=7'h00 inside a full scan -> blank[5]=1, digits[23:20]=4'hF; seg=7'h7E on digit 2 -> digit_err=1.
REQ-035 SEGDEC_TIMEOUT_EN, TIMEOUT_CYC=50: cat held 8'hFF 60 cycles -> stale=1 at cycle 50; next accept -> stale=0.
REQ-036 Reset after 5 of 8 digits accepted, then full scan -> exactly one frame_valid, reset values visible until it.
